// File: rtl/spike_rate_monitor_if.sv
// Record readout channel of the spike rate monitor: valid/ready handshake
// carrying one {rate, ISI} record per transfer.
interface spike_rate_monitor_if #(
  parameter int unsigned RATE_W = 8,
  parameter int unsigned ISI_W  = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [RATE_W-1:0] out_rate;
  logic [ISI_W-1:0]  out_isi;

  modport master (output out_valid, output out_rate, output out_isi, input out_ready);
  modport slave  (input out_valid, input out_rate, input out_isi, output out_ready);
endinterface

// File: rtl/spike_rate_monitor.sv
// Counts spike onsets per programmable window, tracks the latest inter-spike
// interval and queues one {rate, ISI} record per window in a small FIFO.
module spike_rate_monitor #(
  parameter int unsigned RATE_W = 8,
  parameter int unsigned ISI_W  = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             spike_in,
  input  logic                   enable,
  input  logic [ISI_W-1:0]       window_len,
  spike_rate_monitor_if.master   rec,
  output logic                   dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam logic [ISI_W-1:0]  ISI_MAX  = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_spk_prev;
  logic [ISI_W-1:0]  r_len_q;
  logic [ISI_W-1:0]  r_win_cnt;
  logic [RATE_W-1:0] r_rate_cnt;
  logic [ISI_W-1:0]  r_isi_cnt;
  logic [ISI_W-1:0]  r_last_isi;
  logic              r_seen_first;

  logic [RATE_W-1:0] r_mem_rate [DEPTH];
  logic [ISI_W-1:0]  r_mem_isi  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_dropped;

  logic              w_spk;
  logic              w_onset;
  logic              w_run;
  logic              w_close;
  logic [RATE_W-1:0] w_rate_nxt;
  logic [ISI_W-1:0]  w_isi_inc;
  logic [ISI_W-1:0]  w_last_isi_nxt;
  logic [ISI_W-1:0]  w_len_sample;
  logic              w_valid;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle updated values; the close cycle pushes these primed values
  always_comb begin
    w_spk          = |spike_in;
    w_onset        = w_spk & ~r_spk_prev;
    w_run          = (r_state == ST_RUN) & enable;
    w_close        = w_run & (r_win_cnt == (r_len_q - ISI_W'(1)));
    w_rate_nxt     = (w_onset && (r_rate_cnt != RATE_MAX)) ? r_rate_cnt + RATE_W'(1) : r_rate_cnt;
    w_isi_inc      = (r_isi_cnt == ISI_MAX) ? r_isi_cnt : r_isi_cnt + ISI_W'(1);
    w_last_isi_nxt = (w_onset && r_seen_first) ? w_isi_inc : r_last_isi;
    w_len_sample   = (window_len == '0) ? ISI_W'(1) : window_len;
  end

  // Window / rate / ISI counters; IDLE holds everything cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spk_prev   <= 1'b0;
      r_len_q      <= ISI_W'(1);
      r_win_cnt    <= '0;
      r_rate_cnt   <= '0;
      r_isi_cnt    <= '0;
      r_last_isi   <= '0;
      r_seen_first <= 1'b0;
    end else begin
      r_spk_prev <= w_spk;
      if (r_state == ST_IDLE) begin
        r_win_cnt    <= '0;
        r_rate_cnt   <= '0;
        r_isi_cnt    <= '0;
        r_last_isi   <= '0;
        r_seen_first <= 1'b0;
        if (enable) r_len_q <= w_len_sample;
      end else if (w_run) begin
        if (w_close) begin
          r_win_cnt  <= '0;
          r_rate_cnt <= '0;
          r_len_q    <= w_len_sample;
        end else begin
          r_win_cnt  <= r_win_cnt + ISI_W'(1);
          r_rate_cnt <= w_rate_nxt;
        end
        r_last_isi <= w_last_isi_nxt;
        if (w_onset) begin
          r_seen_first <= 1'b1;
          r_isi_cnt    <= '0;
        end else if (r_seen_first) begin
          r_isi_cnt <= w_isi_inc;
        end
      end
    end
  end

  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == CW'(DEPTH));
    w_pop   = w_valid & rec.out_ready;
    w_wr    = w_close & (~w_full | w_pop);
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_close && w_full && !w_pop) r_dropped <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_rate[r_wr_ptr] <= w_rate_nxt;
      r_mem_isi[r_wr_ptr]  <= w_last_isi_nxt;
    end
  end

  assign rec.out_valid = w_valid;
  assign rec.out_rate  = w_valid ? r_mem_rate[r_rd_ptr] : '0;
  assign rec.out_isi   = w_valid ? r_mem_isi[r_rd_ptr]  : '0;
  assign dropped       = r_dropped;

endmodule

// File: doc/spike_rate_monitor.md
# spike_rate_monitor

Downstream consumer of the Hodgkin-Huxley neuron's `spike` output. Detects spike onsets, counts them over a programmable window of clock cycles, and tracks the most recent inter-spike interval (ISI). One {rate, ISI} record is produced per window and buffered in a small FIFO behind a valid/ready handshake for readout logic.

## Interface
- `RATE_W`, 8: width of per-window onset count; saturates at 2^RATE_W-1.
- `ISI_W`, 16: width of ISI counter and window length; saturates at 2^ISI_W-1.
- `DEPTH`, 4: record FIFO depth; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spike_in`  in  8  neuron spike; any nonzero value = spike level high.
- `enable`  in  1  run monitoring; low = idle.
- `window_len`  in  ISI_W  window length in cycles; 0 is treated as 1.
- `out_valid`  out  1  FIFO head record available.
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`.
- `out_rate`  out  RATE_W  head record onset count.
- `out_isi`  out  ISI_W  head record last ISI in cycles; 0 = fewer than two onsets seen.
- `dropped`  out  1  sticky: a record was lost to a full FIFO.

## Operation
- Onset detection: `spk_prev` registers `(spike_in != 0)` every cycle, in all states. onset = `(spike_in != 0) & !spk_prev`. A level held N cycles is one onset.
- FSM states:
  - IDLE: entered on reset. Counters are held at 0.
  - RUN: entered from IDLE when `enable` = 1. Returns to IDLE when `enable` = 0.
- Entry to RUN:
  - Sample `window_len` into `len_q` (0 → 1).
  - Clear `win_cnt`, `rate_cnt`, `isi_cnt`, `last_isi` and `seen_first`.
  - The first RUN cycle is window cycle 0.
- Each RUN cycle:
  - `win_cnt` increments.
  - On onset, `rate_cnt` increments, saturating at max.
- ISI tracking:
  - `isi_cnt` increments (saturating) every RUN cycle once `seen_first` = 1.
  - On onset with `seen_first` = 1: `last_isi` ← min(`isi_cnt`+1, max), and `isi_cnt` ← 0.
  - On the first onset: set `seen_first`, and `isi_cnt` ← 0.
- Window close occurs in the RUN cycle where `win_cnt` == `len_q`-1.
  - That cycle's onset is included in the record.
  - Push {rate_cnt', last_isi'}, where the primes denote values updated for this cycle.
  - Then `win_cnt` ← 0, `rate_cnt` ← 0, and `len_q` ← current `window_len`.
  - `isi_cnt`, `last_isi` and `seen_first` persist across windows.
- Enable deasserted mid-window: the partial window is discarded and nothing is pushed. FIFO contents are retained and remain readable in IDLE.
- FIFO:
  - Push when full and no pop in the same cycle: the record is lost and `dropped` ← 1.
  - Simultaneous push and pop when full: both succeed.
  - Push and pop when empty: the push is stored. The pop is ignored because `out_valid` = 0.
- `dropped` is cleared only by `rst`.
- Arithmetic: all counters are unsigned and saturate; none wrap.

## Timing
- Reset values:
  - `out_valid` = 0, `out_rate` = 0, `out_isi` = 0, `dropped` = 0.
  - FSM = IDLE, `spk_prev` = 0, FIFO empty.
- Latency: a record pushed at the close-cycle edge gives `out_valid` = 1 in the next cycle.
- Output data: `out_rate` and `out_isi` are held stable while `out_valid & !out_ready`.
- Pop takes effect at the edge where `out_valid & out_ready`. The next record or `out_valid` = 0 is visible in the following cycle.
- Throughput: one record per cycle both in and out, e.g. `window_len` = 1.
- `rst` asserted mid-operation: all state returns to its reset value at that edge, including FIFO contents, `dropped` and `spk_prev`. No record is emitted.
- `window_len` changes mid-window take effect only at the next window boundary.

## Test plan
- **Basic window.** Setup: `window_len` = 20, `out_ready` = 1, 1-cycle pulses at RUN cycles 2, 7, 12, 17. Required response: record {rate = 4, isi = 5}, with `out_valid` high one cycle after RUN cycle 19.
- **Held level and cross-window ISI.** Setup: `spike_in` = 8'h01 held for 6 cycles, then a second onset 30 cycles after the first, with `window_len` = 16. Required response: windows report rate = 1, 1 or 0 as placed. `out_isi` = 30 once the second onset is recorded, and 0 before that.
- **Saturation.** Setup: `window_len` = 600, one onset every 2 cycles. Required response: rate = 255 and isi = 2.
- **FIFO full.** Setup: `out_ready` = 0, `window_len` = 4, run 5 windows. Required response: first 4 records are retained and `dropped` = 1. Raising `out_ready` then drains exactly 4 records in order.
- **Enable drop and reset.** Setup: deassert `enable` at window cycle 10 of 20. Required response: no record is emitted. After re-enable, the window restarts from cycle 0 with `out_isi` = 0. Then assert `rst` with 2 records queued: `out_valid` = 0 and `dropped` = 0 next cycle.
